msdf_mult_seq: RTL and testbench

//  Sequencer for msdf_mult, the online MSB-first digit-serial multiplier.

---
 rtl/msdf_mult_seq.sv | 167 ++++++++++++++++
 tb/tb_msdf_mult_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/msdf_mult_seq.sv
// Sequencer for the online MSB-first multiplier: latches two signed-digit operands,
// feeds them one digit per cycle with flush digits and phase strobes, and collects the product.
module msdf_mult_seq #(
    parameter int NDIG     = 8,
    parameter int P_LAT    = 3,
    parameter int V1_START = 2,
    parameter int V3_START = 4
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [2*NDIG-1:0] x_par_i,
    input  logic [2*NDIG-1:0] y_par_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [2*NDIG-1:0] p_par_o,
    output logic              m_reset_o,
    output logic [1:0]        m_xi_o,
    output logic [1:0]        m_yi_o,
    output logic              m_valid_o,
    output logic              m_valid2_o,
    output logic              m_valid3_o,
    input  logic [1:0]        m_p_i
);

    localparam int W       = 2*NDIG;
    localparam int RUN_LEN = NDIG + P_LAT;
    localparam int SW      = $clog2(RUN_LEN + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_DONE, S_ABRT} state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  step_q, step_d;
    logic [W-1:0]   xsh_q, xsh_d, ysh_q, ysh_d;
    logic [W-1:0]   cap_q, cap_d, p_par_q, p_par_d;
    logic           busy_q, busy_d, done_q, done_d, err_q, err_d, mrst_q, mrst_d;
    logic [1:0]     mxi_q, mxi_d, myi_q, myi_d;
    logic           v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic           illegal;

    always_comb begin
        illegal = 1'b0;
        for (int i = 0; i < NDIG; i++)
            if ((&x_par_i[2*i +: 2]) || (&y_par_i[2*i +: 2])) illegal = 1'b1;

        state_d = state_q;
        step_d  = step_q;
        xsh_d   = xsh_q;
        ysh_d   = ysh_q;
        cap_d   = cap_q;
        p_par_d = p_par_q;
        err_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        mrst_d  = 1'b0;
        mxi_d   = 2'b00;
        myi_d   = 2'b00;
        v1_d    = 1'b0;
        v2_d    = 1'b0;
        v3_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_CLR;
                        xsh_d   = x_par_i;
                        ysh_d   = y_par_i;
                    end
                end
            end
            S_CLR: begin
                if (abort_i) state_d = S_ABRT;
                else begin
                    state_d = S_RUN;
                    step_d  = '0;
                end
            end
            S_RUN: begin
                // Digits arriving before the online delay has elapsed are not product digits.
                if (step_q >= SW'(P_LAT)) cap_d = {cap_q[W-3:0], m_p_i};
                if (abort_i) state_d = S_ABRT;
                else if (step_q == SW'(RUN_LEN-1)) begin
                    state_d = S_DONE;
                    p_par_d = cap_d;
                end else step_d = step_q + SW'(1);
            end
            S_DONE:  state_d = S_IDLE;
            S_ABRT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Ports are registered, so drive them from the state being entered.
        case (state_d)
            S_CLR: begin
                busy_d = 1'b1;
                mrst_d = 1'b1;
            end
            S_ABRT: mrst_d = 1'b1;
            S_DONE: done_d = 1'b1;
            S_RUN: begin
                busy_d = 1'b1;
                v2_d   = 1'b1;
                v1_d   = (step_d >= SW'(V1_START));
                v3_d   = (step_d >= SW'(V3_START));
                // Zeros shift in behind the operand, giving the flush digits for free.
                mxi_d  = xsh_q[W-1 -: 2];
                myi_d  = ysh_q[W-1 -: 2];
                xsh_d  = xsh_q << 2;
                ysh_d  = ysh_q << 2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            xsh_q   <= '0;
            ysh_q   <= '0;
            cap_q   <= '0;
            p_par_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            mrst_q  <= 1'b1;
            mxi_q   <= 2'b00;
            myi_q   <= 2'b00;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            xsh_q   <= xsh_d;
            ysh_q   <= ysh_d;
            cap_q   <= cap_d;
            p_par_q <= p_par_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            mrst_q  <= mrst_d;
            mxi_q   <= mxi_d;
            myi_q   <= myi_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign p_par_o    = p_par_q;
    assign m_reset_o  = mrst_q;
    assign m_xi_o     = mxi_q;
    assign m_yi_o     = myi_q;
    assign m_valid_o  = v1_q;
    assign m_valid2_o = v2_q;
    assign m_valid3_o = v3_q;

endmodule

// File: tb/tb_msdf_mult_seq.sv
// Bench for msdf_mult_seq: a behavioural online multiplier answers the digit stream,
// and products are checked by value against exact integer arithmetic.
module tb_msdf_mult_seq;

    localparam int N  = 8;
    localparam int W  = 2*N;
    localparam int PL = 3;

    logic         clk, rst_n, start, abort;
    logic [W-1:0] x_par, y_par, p_par;
    logic         busy, done, err, m_reset, m_valid, m_valid2, m_valid3;
    logic [1:0]   m_xi, m_yi, m_p;

    int     tests = 0;
    int     fails = 0;
    longint last_prod = 0;

    msdf_mult_seq #(.NDIG(N), .P_LAT(PL), .V1_START(2), .V3_START(4)) dut (
        .clk_i(clk), .reset_ni(rst_n), .start_i(start), .abort_i(abort),
        .x_par_i(x_par), .y_par_i(y_par), .busy_o(busy), .done_o(done),
        .err_o(err), .p_par_o(p_par), .m_reset_o(m_reset), .m_xi_o(m_xi),
        .m_yi_o(m_yi), .m_valid_o(m_valid), .m_valid2_o(m_valid2),
        .m_valid3_o(m_valid3), .m_p_i(m_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint dval(input logic [1:0] d);
        if (d == 2'b01) return 1;
        if (d == 2'b10) return -1;
        return 0;
    endfunction

    // Operand value in units of 2^-N, MSD at the top of the word.
    function automatic longint opval(input logic [W-1:0] v);
        longint s = 0;
        for (int i = 0; i < N; i++)
            s += dval(v[W-1-2*i -: 2]) * (64'sd1 <<< (N-1-i));
        return s;
    endfunction

    // Online multiplier stand-in: after seeing digit s, the known prefixes bound the
    // product to within 2^-s, so digit s-PL is chosen by rounding the residual.
    int     mcnt;
    longint mX, mY, mE, mw, mr;
    always @(negedge clk) begin
        if (!rst_n || m_reset) begin
            mcnt = 0; mX = 0; mY = 0; mE = 0; m_p = 2'b00;
        end else if (m_valid2) begin
            if (mcnt < N) begin
                mX += dval(m_xi) * (64'sd1 <<< (N-1-mcnt));
                mY += dval(m_yi) * (64'sd1 <<< (N-1-mcnt));
            end
            m_p = 2'b00;
            if (mcnt >= PL && mcnt - PL < N) begin
                mw = 64'sd1 <<< (2*N - (mcnt - PL) - 1);
                mr = mX*mY - mE;
                if (2*mr >= mw) begin m_p = 2'b01; mE += mw; end
                else if (2*mr <= -mw) begin m_p = 2'b10; mE -= mw; end
            end
            mcnt++;
        end else m_p = 2'b00;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // exp is in units of 2^-2N; tolerance is one result ulp (2^-N).
    task automatic chk_prod(input string tag, input logic [W-1:0] p, input longint exp);
        longint diff;
        diff = opval(p) * (64'sd1 <<< N) - exp;
        tests++;
        assert (diff <= (64'sd1 <<< N) && diff >= -(64'sd1 <<< N)) else begin
            fails++;
            $error("FAIL %s: p_par value %0d/2^%0d expected %0d/2^%0d",
                   tag, opval(p), N, exp, 2*N);
        end
    endtask

    // One start; poke>0 pulses start with other operands at that cycle.
    task automatic run_and_check(input string tag, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input int poke);
        int lat, nb, nr, f1, f2, f3;
        lat = -1; nb = 0; nr = 0; f1 = -1; f2 = -1; f3 = -1;
        @(negedge clk); x_par = x; y_par = y; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            if (c == poke) begin
                start = 1'b1; x_par = {(W/2){2'b01}}; y_par = {(W/2){2'b10}};
            end else start = 1'b0;
            if (busy) nb++;
            if (m_reset) nr++;
            if (m_valid  && f1 < 0) f1 = c;
            if (m_valid2 && f2 < 0) f2 = c;
            if (m_valid3 && f3 < 0) f3 = c;
            if (done) begin lat = c; break; end
        end
        start = 1'b0;
        chk({tag, ".latency"}, lat, N + PL + 2);
        chk({tag, ".busy_cycles"}, nb, N + PL + 1);
        chk({tag, ".mreset_cycles"}, nr, 1);
        chk({tag, ".valid2_first"}, f2, 2);
        chk({tag, ".valid_first"}, f1, 4);
        chk({tag, ".valid3_first"}, f3, 6);
        last_prod = opval(x) * opval(y);
        chk_prod({tag, ".product"}, p_par, last_prod);
        @(negedge clk);
        chk({tag, ".busy_after"}, busy, 0);
        chk({tag, ".done_after"}, done, 0);
    endtask

    initial begin
        int nd, nrise;
        int rise [3];
        logic pb;
        logic [W-1:0] rx, ry;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; x_par = '0; y_par = '0;
        @(negedge clk);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.err", err, 0);
        chk("rst.p_par", p_par, 0);
        chk("rst.m_reset", m_reset, 1);
        chk("rst.strobes_digits", {m_valid, m_valid2, m_valid3, m_xi, m_yi}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.m_reset_release", m_reset, 0);

        run_and_check("directed", 16'h4000, 16'h4000, -1);
        run_and_check("sign", 16'h8000, 16'h4000, -1);

        // Illegal digit is rejected without disturbing anything.
        @(negedge clk); x_par = 16'hC000; y_par = 16'h4000; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("illegal.err", err, 1);
        chk("illegal.busy", busy, 0);
        chk("illegal.m_reset", m_reset, 0);
        chk("illegal.strobes", {m_valid, m_valid2, m_valid3}, 0);
        chk_prod("illegal.p_par_kept", p_par, last_prod);
        @(negedge clk);
        chk("illegal.err_pulse", err, 0);
        chk("illegal.busy_later", busy, 0);

        // Abort at s=4 (cycle 6 after the start cycle).
        @(negedge clk); x_par = 16'h4000; y_par = 16'h6000; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort.m_reset", m_reset, 1);
        chk("abort.busy", busy, 0);
        chk("abort.strobes", {m_valid, m_valid2, m_valid3}, 0);
        @(negedge clk);
        chk("abort.m_reset_drop", m_reset, 0);
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("abort.no_done_or_busy", nd, 0);
        chk_prod("abort.p_par_kept", p_par, last_prod);
        run_and_check("after_abort", 16'h6000, 16'h9000, -1);

        // Abort and start together in IDLE: nothing starts.
        @(negedge clk); x_par = 16'h4000; y_par = 16'h4000; start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("abort_start.busy", busy, 0);
        chk("abort_start.m_reset", m_reset, 0);

        // Async reset at s=6, held two cycles.
        @(negedge clk); x_par = 16'h5000; y_par = 16'h4800; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.busy", busy, 0);
        chk("midrst.p_par", p_par, 0);
        chk("midrst.m_reset", m_reset, 1);
        chk("midrst.strobes_digits", {m_valid, m_valid2, m_valid3, m_xi, m_yi}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst.m_reset_held", m_reset, 1);
        @(negedge clk);
        chk("midrst.m_reset_fall", m_reset, 0);
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("midrst.no_done", nd, 0);
        last_prod = 0;

        // Start held high: a new run every N+PL+3 cycles.
        @(negedge clk); x_par = 16'h9000; y_par = 16'h5000; start = 1'b1;
        nd = 0; nrise = 0; pb = busy;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (busy && !pb && nrise < 3) begin rise[nrise] = c; nrise++; end
            pb = busy;
            if (nrise == 3) start = 1'b0;
            if (done) begin
                nd++;
                chk_prod("b2b.product", p_par, opval(16'h9000) * opval(16'h5000));
                if (nd == 3) break;
            end
        end
        start = 1'b0;
        chk("b2b.runs", nd, 3);
        chk("b2b.period1", rise[1] - rise[0], N + PL + 3);
        chk("b2b.period2", rise[2] - rise[1], N + PL + 3);
        repeat (2) @(negedge clk);
        chk("b2b.idle_after", busy, 0);

        run_and_check("busy_ignore", 16'h4000, 16'h6400, 5);

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < N; i++) begin
                rx[2*i +: 2] = 2'($urandom_range(0, 2));
                ry[2*i +: 2] = 2'($urandom_range(0, 2));
            end
            run_and_check("random", rx, ry, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
